// File: rtl/gpr_scoreboard_rf_pkg.sv
// Shared sizing constants for the GPR file and its pending-write scoreboard.
package gpr_scoreboard_rf_pkg;

    localparam int unsigned GPR_DATA_W = 16;
    localparam int unsigned GPR_NREG   = 16;
    localparam int unsigned GPR_NUM_W  = 4;
    localparam int unsigned GPR_CNT_W  = 2;

    // Selectors for the decoders: one-hot strobe for register n when en is set.
    function automatic logic [GPR_NREG-1:0] gpr_onehot(input logic en,
                                                       input logic [GPR_NUM_W-1:0] n);
        logic [GPR_NREG-1:0] v;
        v = '0;
        v[n] = en;
        return v;
    endfunction

endpackage

// File: rtl/gpr_scoreboard_rf_sb_cell.sv
// One general-purpose register plus its saturating pending-write counter.
module gpr_sb_cell
    import gpr_scoreboard_rf_pkg::*;
#(
    parameter int unsigned DATA_W = GPR_DATA_W,
    parameter int unsigned CNT_W  = GPR_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic              inc,
    input  logic              dec,
    output logic [DATA_W-1:0] data_o,
    output logic              pend_o,
    output logic              err_o
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Counter update; a simultaneous reserve and retire cancel without error.
    always_comb begin
        cnt_nxt = cnt;
        err_o   = 1'b0;
        if (inc && !dec) begin
            if (cnt == '1) err_o   = 1'b1;
            else           cnt_nxt = cnt + CNT_W'(1);
        end else if (dec && !inc) begin
            if (cnt == '0) err_o   = 1'b1;
            else           cnt_nxt = cnt - CNT_W'(1);
        end
    end

    // Register data and counter state, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_o <= '0;
            cnt    <= '0;
        end else begin
            if (we) data_o <= wdata;
            cnt <= cnt_nxt;
        end
    end

    assign pend_o = (cnt != '0);

endmodule

// File: rtl/gpr_scoreboard_rf.sv
// 16-entry register file with per-register pending-write scoreboard and WB->ID bypass.
module gpr_scoreboard_rf
    import gpr_scoreboard_rf_pkg::*;
#(
    parameter int unsigned DATA_W = GPR_DATA_W,
    parameter int unsigned NREG   = GPR_NREG,
    parameter int unsigned NUM_W  = GPR_NUM_W,
    parameter int unsigned CNT_W  = GPR_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_W-1:0]  r0_num,
    input  logic [NUM_W-1:0]  r1_num,
    output logic [DATA_W-1:0] r0_data,
    output logic [DATA_W-1:0] r1_data,
    input  logic              w_reserve,
    input  logic [NUM_W-1:0]  w_num,
    output logic [NREG-1:0]   reserved,
    input  logic              wb,
    input  logic [NUM_W-1:0]  wbr_num,
    input  logic [DATA_W-1:0] wb_data,
    output logic              sb_err,
    input  logic [NUM_W-1:0]  dbg_num,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   inc_vec;
    logic [NREG-1:0]   dec_vec;
    logic [NREG-1:0]   err_vec;

    // Reserve and writeback decoders.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            inc_vec[i] = w_reserve && (w_num == NUM_W'(i));
            dec_vec[i] = wb && (wbr_num == NUM_W'(i));
        end
    end

    for (genvar g = 0; g < int'(NREG); g++) begin : g_cell
        gpr_sb_cell #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .we     (dec_vec[g]),
            .wdata  (wb_data),
            .inc    (inc_vec[g]),
            .dec    (dec_vec[g]),
            .data_o (regs[g]),
            .pend_o (reserved[g]),
            .err_o  (err_vec[g])
        );
    end

    // Operand reads with same-cycle writeback bypass; debug read sees the array only.
    always_comb begin
        r0_data  = (wb && (wbr_num == r0_num)) ? wb_data : regs[r0_num];
        r1_data  = (wb && (wbr_num == r1_num)) ? wb_data : regs[r1_num];
        dbg_data = regs[dbg_num];
    end

    // Sticky protocol-error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst)          sb_err <= 1'b0;
        else if (|err_vec) sb_err <= 1'b1;
    end

endmodule

// File: tb/tb_gpr_scoreboard_rf.sv
// Directed scoreboard bench for gpr_scoreboard_rf.
module tb_gpr_scoreboard_rf;

    logic        clk;
    logic        rst;
    logic [3:0]  r0_num, r1_num, w_num, wbr_num, dbg_num;
    logic [15:0] r0_data, r1_data, dbg_data, wb_data;
    logic [15:0] reserved;
    logic        w_reserve, wb, sb_err;

    int n_vec = 0;
    int n_err = 0;

    gpr_scoreboard_rf dut (
        .clk       (clk),
        .rst       (rst),
        .r0_num    (r0_num),
        .r1_num    (r1_num),
        .r0_data   (r0_data),
        .r1_data   (r1_data),
        .w_reserve (w_reserve),
        .w_num     (w_num),
        .reserved  (reserved),
        .wb        (wb),
        .wbr_num   (wbr_num),
        .wb_data   (wb_data),
        .sb_err    (sb_err),
        .dbg_num   (dbg_num),
        .dbg_data  (dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fail(input string n, input logic [15:0] got, input logic [15:0] e);
        n_err++;
        $display("FAIL %s: got %h, expected %h", n, got, e);
    endtask

    task automatic idle();
        w_reserve = 1'b0;
        wb        = 1'b0;
    endtask

    initial begin
        rst = 1'b0; r0_num = '0; r1_num = '0; w_num = '0; dbg_num = '0;
        w_reserve = 1'b0; wb = 1'b1; wbr_num = 4'd3; wb_data = 16'hBEEF;
        @(posedge clk); @(posedge clk); #1;

        // Reset with a concurrent writeback that must be ignored.
        rst = 1'b1; idle(); dbg_num = 4'd3;
        #1;
        n_vec++; if (reserved !== 16'h0000) fail("reset_reserved", reserved, 16'h0000);
        n_vec++; if (sb_err !== 1'b0) fail("reset_sb_err", {15'b0, sb_err}, 16'h0000);
        n_vec++; if (dbg_data !== 16'h0000) fail("reset_dbg_r3", dbg_data, 16'h0000);

        // Reserve r5, visible next cycle; retire it three cycles later.
        w_reserve = 1'b1; w_num = 4'd5;
        #1;
        n_vec++; if (reserved !== 16'h0000) fail("reserve_not_yet", reserved, 16'h0000);
        step(); idle();
        n_vec++; if (reserved !== 16'h0020) fail("reserve_r5", reserved, 16'h0020);
        step(); step();
        wb = 1'b1; wbr_num = 4'd5; wb_data = 16'h1234;
        #1;
        n_vec++; if (reserved !== 16'h0020) fail("retire_pending", reserved, 16'h0020);
        step(); idle(); dbg_num = 4'd5;
        #1;
        n_vec++; if (reserved !== 16'h0000) fail("retire_reserved", reserved, 16'h0000);
        n_vec++; if (dbg_data !== 16'h1234) fail("retire_dbg_r5", dbg_data, 16'h1234);
        n_vec++; if (sb_err !== 1'b0) fail("retire_sb_err", {15'b0, sb_err}, 16'h0000);

        // Bypass: reserve r5 again, then retire it while both read ports select r5.
        w_reserve = 1'b1; w_num = 4'd5;
        step(); idle();
        r0_num = 4'd5; r1_num = 4'd5;
        wb = 1'b1; wbr_num = 4'd5; wb_data = 16'hABCD;
        #1;
        n_vec++; if (r0_data !== 16'hABCD) fail("bypass_r0", r0_data, 16'hABCD);
        n_vec++; if (r1_data !== 16'hABCD) fail("bypass_r1", r1_data, 16'hABCD);
        n_vec++; if (dbg_data !== 16'h1234) fail("bypass_dbg_old", dbg_data, 16'h1234);
        step(); idle();
        #1;
        n_vec++; if (r0_data !== 16'hABCD) fail("after_bypass_r0", r0_data, 16'hABCD);
        n_vec++; if (dbg_data !== 16'hABCD) fail("after_bypass_dbg", dbg_data, 16'hABCD);
        n_vec++; if (sb_err !== 1'b0) fail("after_bypass_err", {15'b0, sb_err}, 16'h0000);

        // Same-cycle reserve and retire of r7 keeps it pending.
        w_reserve = 1'b1; w_num = 4'd7;
        step(); idle();
        w_reserve = 1'b1; w_num = 4'd7; wb = 1'b1; wbr_num = 4'd7; wb_data = 16'h7777;
        step(); idle();
        #1;
        n_vec++; if (reserved !== 16'h0080) fail("incdec_reserved", reserved, 16'h0080);
        wb = 1'b1; wbr_num = 4'd7; wb_data = 16'h7778;
        step(); idle(); dbg_num = 4'd7;
        #1;
        n_vec++; if (reserved !== 16'h0000) fail("incdec_cleared", reserved, 16'h0000);
        n_vec++; if (sb_err !== 1'b0) fail("incdec_sb_err", {15'b0, sb_err}, 16'h0000);
        n_vec++; if (dbg_data !== 16'h7778) fail("incdec_dbg_r7", dbg_data, 16'h7778);

        // Reserve one register while retiring a different one.
        w_reserve = 1'b1; w_num = 4'd7;
        step(); idle();
        w_reserve = 1'b1; w_num = 4'd10; wb = 1'b1; wbr_num = 4'd7; wb_data = 16'h0707;
        step(); idle();
        #1;
        n_vec++; if (reserved !== 16'h0400) fail("cross_reserved", reserved, 16'h0400);
        n_vec++; if (dbg_data !== 16'h0707) fail("cross_dbg_r7", dbg_data, 16'h0707);
        wb = 1'b1; wbr_num = 4'd10; wb_data = 16'h0A0A;
        step(); idle();
        #1;
        n_vec++; if (reserved !== 16'h0000) fail("cross_cleared", reserved, 16'h0000);

        // Overflow: four reservations of r2 saturate the 2-bit counter.
        w_reserve = 1'b1; w_num = 4'd2;
        step(); step(); step();
        n_vec++; if (sb_err !== 1'b0) fail("ovf_three_err", {15'b0, sb_err}, 16'h0000);
        n_vec++; if (reserved !== 16'h0004) fail("ovf_three_res", reserved, 16'h0004);
        step(); idle();
        #1;
        n_vec++; if (sb_err !== 1'b1) fail("ovf_sb_err", {15'b0, sb_err}, 16'h0001);
        wb = 1'b1; wbr_num = 4'd2; wb_data = 16'h0002;
        step(); step();
        n_vec++; if (reserved !== 16'h0004) fail("ovf_two_wb_res", reserved, 16'h0004);
        step(); idle();
        #1;
        n_vec++; if (reserved !== 16'h0000) fail("ovf_drained_res", reserved, 16'h0000);
        n_vec++; if (sb_err !== 1'b1) fail("ovf_sticky_err", {15'b0, sb_err}, 16'h0001);

        // Underflow: writeback with no reservation after a fresh reset.
        rst = 1'b0;
        step(); rst = 1'b1;
        #1;
        n_vec++; if (sb_err !== 1'b0) fail("rst2_sb_err", {15'b0, sb_err}, 16'h0000);
        n_vec++; if (reserved !== 16'h0000) fail("rst2_reserved", reserved, 16'h0000);
        wb = 1'b1; wbr_num = 4'd9; wb_data = 16'h0042;
        #1;
        n_vec++; if (sb_err !== 1'b0) fail("unf_err_pre", {15'b0, sb_err}, 16'h0000);
        step(); idle(); dbg_num = 4'd9;
        #1;
        n_vec++; if (dbg_data !== 16'h0042) fail("unf_dbg_r9", dbg_data, 16'h0042);
        n_vec++; if (reserved !== 16'h0000) fail("unf_reserved", reserved, 16'h0000);
        n_vec++; if (sb_err !== 1'b1) fail("unf_sb_err", {15'b0, sb_err}, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gpr_scoreboard_rf.md
Name: gpr_scoreboard_rf

Overview:
- Responder side of the ID<->RF and WB-->RF interfaces: the 16-entry general-purpose register file plus a per-register pending-write scoreboard.
- ID reads two operands and reserves a destination. WB retires writes.
- `reserved` tells ID which registers still have an in-flight producer so ID can stall.
- Replaces the plain register array inside core.

Parameters:
- DATA_W, 16, register width in bits
- NREG, 16, number of registers (power of two)
- NUM_W, 4, register-number width, equal to log2(NREG)
- CNT_W, 2, pending-write counter width per register

Ports:
- clk  in  1  clock
- rst  in  1  reset
- r0_num  in  NUM_W  read port 0 register number
- r1_num  in  NUM_W  read port 1 register number
- r0_data  out  DATA_W  read port 0 data
- r1_data  out  DATA_W  read port 1 data
- w_reserve  in  1  ID reserves w_num as a pending destination this cycle
- w_num  in  NUM_W  register to reserve
- reserved  out  NREG  bit i = 1 while register i has at least one pending write
- wb  in  1  WB write strobe
- wbr_num  in  NUM_W  write register number
- wb_data  in  DATA_W  write data
- sb_err  out  1  sticky protocol-error flag
- dbg_num  in  NUM_W  debug read select
- dbg_data  out  DATA_W  debug read data, no bypass

Behaviour:
- Reset and clock: rst is synchronous, active-low; clock clk. While rst=0 at a posedge:
  - all registers clear to 0;
  - all pending counters clear to 0, so reserved = 0;
  - sb_err clears to 0.
  - Reset mid-operation discards all pending reservations; a wb arriving in the same cycle is ignored.
- Reads are combinational, zero latency.
  - r0_data = (wb && wbr_num==r0_num) ? wb_data : regs[r0_num]. Same rule for r1_data.
  - This write-to-read bypass is mandatory so ID sees the retiring value in the same cycle.
  - dbg_data = regs[dbg_num], with no bypass.
- Writes: at a posedge with rst=1 and wb=1, regs[wbr_num] <= wb_data.
- Pending counter cnt[i], CNT_W bits, evaluated per posedge with rst=1:
  - inc = w_reserve && w_num==i; dec = wb && wbr_num==i.
  - inc && !dec: cnt+1. If cnt is already all-ones, hold it and set sb_err (overflow).
  - dec && !inc: cnt-1. If cnt==0, hold at 0, still perform the data write, and set sb_err (underflow: write with no reservation).
  - inc && dec: cnt unchanged. No error, even when cnt==0 or cnt is saturated.
  - Otherwise: unchanged.
- reserved[i] = (cnt[i] != 0). It is registered state, so a reservation becomes visible the cycle after w_reserve.
- Same-cycle reserve and retire of one register leaves reserved[i] equal to its prior value. This covers back-to-back writers to the same register.
- sb_err is sticky until reset.
- Registers are independent; there is no hardwired-zero register.
- A reserve for one register and a writeback to a different register in the same cycle are both applied.

Decomposition:
- Shared header (params.vh): DATA_W, NREG, NUM_W, CNT_W defaults and register-number constants.
- One sub-module, gpr_sb_cell: one register and its counter.
  - Inputs: clk, rst, we, wdata, inc, dec.
  - Outputs: data_o, pend_o, err_o.
  - Instantiated NREG times by generate.
  - The top level holds the read muxes, the bypass, the decoders and the sb_err OR-reduce/sticky flop.

Test Plan:
- Reset: drive rst=0 for 2 cycles with wb=1, wbr_num=3, wb_data=16'hBEEF → all regs 0, reserved=16'h0000, sb_err=0, dbg_num=3 reads 0.
- Reserve/retire: w_reserve, w_num=5 at cycle 1 → reserved=16'h0020 from cycle 2. At cycle 4 wb, wbr_num=5, wb_data=16'h1234 → reserved=16'h0000 from cycle 5, dbg r5=16'h1234, sb_err=0.
- Bypass: r5=16'h1234. Drive r0_num=5, r1_num=5, wb, wbr_num=5, wb_data=16'hABCD in the same cycle → r0_data=r1_data=16'hABCD in that cycle; r5=16'hABCD afterwards.
- Same-cycle inc and dec: cnt[7]=1. Reserve 7 and wb 7 in the same cycle → reserved[7] stays 1. A further wb to 7 → reserved[7]=0, sb_err=0.
- Overflow: reserve register 2 for 4 consecutive cycles (CNT_W=2) → cnt saturates at 3 and sb_err=1 after the 4th. Three wbs to 2 → reserved[2]=0, sb_err stays 1.
- Underflow: after reset, wb to register 9 with 16'h0042 and no reservation → r9=16'h0042, reserved[9]=0, sb_err=1 the next cycle.
